// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types and constants for the video test pattern checker
// Contents: rgb_t pixel type, colour-bar and black/white constants,
//           pattern_sel encodings, checker FSM state type, coordinate limit.
package pattern_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_RED     = 24'hFF0000;
    localparam rgb_t RGB_GREEN   = 24'h00FF00;
    localparam rgb_t RGB_BLUE    = 24'h0000FF;
    localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb_t RGB_CYAN    = 24'h00FFFF;
    localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb_t RGB_ORANGE  = 24'hFF8000;
    localparam rgb_t RGB_BLACK   = 24'h000000;

    localparam logic PAT_BARS  = 1'b0;
    localparam logic PAT_CHECK = 1'b1;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        CHECK,
        REPORT
    } chk_state_t;

    localparam logic [9:0] COORD_MAX = 10'h3FF;

endpackage

// File: rtl/pattern_expect.sv
// rtl/pattern_expect.sv - expected test-pattern colour for a pixel coordinate
// Ports: x_i, y_i  pixel coordinate (first active pixel/line = 0)
//        sel_i     PAT_BARS or PAT_CHECK
//        rgb_o     expected colour, combinational
module pattern_expect
    import pattern_pkg::*;
#(
    parameter int BAR_W     = 80,
    parameter int CHECK_BIT = 5
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic       sel_i,
    output rgb_t       rgb_o
);

    localparam logic [9:0] BAR_W_C = 10'(BAR_W);

    logic [9:0] bar_idx;
    rgb_t       bar_rgb;
    rgb_t       chk_rgb;

    assign bar_idx = x_i / BAR_W_C;

    // Bars past the eighth (wide lines) stay orange.
    always_comb begin
        bar_rgb = RGB_ORANGE;
        case (bar_idx)
            10'd0:   bar_rgb = RGB_RED;
            10'd1:   bar_rgb = RGB_GREEN;
            10'd2:   bar_rgb = RGB_BLUE;
            10'd3:   bar_rgb = RGB_WHITE;
            10'd4:   bar_rgb = RGB_YELLOW;
            10'd5:   bar_rgb = RGB_CYAN;
            10'd6:   bar_rgb = RGB_MAGENTA;
            default: bar_rgb = RGB_ORANGE;
        endcase
    end

    assign chk_rgb = (x_i[CHECK_BIT] ^ y_i[CHECK_BIT]) ? RGB_WHITE : RGB_BLACK;
    assign rgb_o   = (sel_i == PAT_CHECK) ? chk_rgb : bar_rgb;

endmodule

// File: rtl/pattern_checker.sv
// rtl/pattern_checker.sv - receive-side test pattern checker with per-frame error statistics
// Ports: clk, rst (sync, active high)
//        vde, vsync, pattern_sel, red/green/blue   received video stream
//        frame_done      one-cycle pulse, results below valid for the finished frame
//        frame_pass      no pixel errors and correct geometry
//        err_count       saturating mismatch count
//        geom_err        wrong pixels/line or lines/frame
//        first_err_valid, first_err_x, first_err_y   first mismatching pixel
module pattern_checker
    import pattern_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BAR_W     = 80,
    parameter int CHECK_BIT = 5,
    parameter int ERR_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vde,
    input  logic             vsync,
    input  logic             pattern_sel,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    output logic             frame_done,
    output logic             frame_pass,
    output logic [ERR_W-1:0] err_count,
    output logic             geom_err,
    output logic             first_err_valid,
    output logic [9:0]       first_err_x,
    output logic [9:0]       first_err_y
);

    localparam logic [9:0]       H_LEN   = 10'(H_ACTIVE);
    localparam logic [9:0]       V_LEN   = 10'(V_ACTIVE);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    chk_state_t state_q, state_d;
    logic acc_clr, acc_en, publish;

    logic vsync_q, vde_q, vs_rise, vde_fall;
    logic [9:0] x_q, x_d, y_q, y_d, cur_x, cur_y;
    logic sel_q, cur_sel;
    rgb_t exp_rgb;

    logic       s1_valid_q;
    rgb_t       s1_rgb_q, s1_exp_q;
    logic [9:0] s1_x_q, s1_y_q;
    logic       mismatch;

    logic [ERR_W-1:0] err_q, err_d;
    logic             geom_q, geom_d, geom_fin;
    logic [9:0]       lines_q, lines_d;
    logic             fv_q, fv_d;
    logic [9:0]       fx_q, fx_d, fy_q, fy_d;

    logic             done_q, pass_q, geom_out_q, fv_out_q;
    logic [ERR_W-1:0] err_out_q;
    logic [9:0]       fx_out_q, fy_out_q;

    assign vs_rise  = vsync & ~vsync_q;
    assign vde_fall = vde_q & ~vde;

    // A pixel coinciding with the vsync edge is already the new frame's (0,0)
    // and uses the freshly selected pattern.
    assign cur_x   = vs_rise ? 10'd0 : x_q;
    assign cur_y   = vs_rise ? 10'd0 : y_q;
    assign cur_sel = vs_rise ? pattern_sel : sel_q;

    always_comb begin
        x_d = cur_x;
        if (vde) begin
            x_d = (cur_x == COORD_MAX) ? cur_x : cur_x + 10'd1;
        end else if (vde_fall) begin
            x_d = 10'd0;
        end
        y_d = cur_y;
        if (vde_fall && !vs_rise && (y_q != COORD_MAX)) begin
            y_d = y_q + 10'd1;
        end
    end

    pattern_expect #(
        .BAR_W     (BAR_W),
        .CHECK_BIT (CHECK_BIT)
    ) u_expect (
        .x_i   (cur_x),
        .y_i   (cur_y),
        .sel_i (cur_sel),
        .rgb_o (exp_rgb)
    );

    assign mismatch = s1_valid_q && (s1_rgb_q != s1_exp_q);

    always_comb begin
        state_d = state_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        publish = 1'b0;
        case (state_q)
            WAIT_FRAME: begin
                if (vs_rise) begin
                    state_d = CHECK;
                    acc_clr = 1'b1;
                end
            end
            CHECK: begin
                acc_en = 1'b1;
                if (vs_rise) begin
                    state_d = REPORT;
                    publish = 1'b1;
                end
            end
            REPORT: begin
                // Results were published on entry; whatever stage 2 holds now
                // was captured on the vsync edge and belongs to the new frame.
                state_d = CHECK;
                acc_clr = 1'b1;
                acc_en  = 1'b1;
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_comb begin
        err_d   = acc_clr ? '0    : err_q;
        geom_d  = acc_clr ? 1'b0  : geom_q;
        lines_d = acc_clr ? 10'd0 : lines_q;
        fv_d    = acc_clr ? 1'b0  : fv_q;
        fx_d    = acc_clr ? 10'd0 : fx_q;
        fy_d    = acc_clr ? 10'd0 : fy_q;
        if (acc_en) begin
            if (mismatch) begin
                if (err_d != ERR_MAX) begin
                    err_d = err_d + ERR_W'(1);
                end
                if (!fv_d) begin
                    fv_d = 1'b1;
                    fx_d = s1_x_q;
                    fy_d = s1_y_q;
                end
            end
            if (vde_fall) begin
                if (x_q != H_LEN) begin
                    geom_d = 1'b1;
                end
                if (lines_d != COORD_MAX) begin
                    lines_d = lines_d + 10'd1;
                end
            end
        end
    end

    // Published on the vsync edge using next-state values so that the last
    // in-flight pixel and a coincident end-of-line both count for this frame.
    assign geom_fin = geom_d | (lines_d != V_LEN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_FRAME;
            vsync_q    <= 1'b0;
            vde_q      <= 1'b0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            sel_q      <= PAT_BARS;
            s1_valid_q <= 1'b0;
            s1_rgb_q   <= RGB_BLACK;
            s1_exp_q   <= RGB_BLACK;
            s1_x_q     <= 10'd0;
            s1_y_q     <= 10'd0;
            err_q      <= '0;
            geom_q     <= 1'b0;
            lines_q    <= 10'd0;
            fv_q       <= 1'b0;
            fx_q       <= 10'd0;
            fy_q       <= 10'd0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_out_q  <= '0;
            geom_out_q <= 1'b0;
            fv_out_q   <= 1'b0;
            fx_out_q   <= 10'd0;
            fy_out_q   <= 10'd0;
        end else begin
            state_q    <= state_d;
            vsync_q    <= vsync;
            vde_q      <= vde;
            x_q        <= x_d;
            y_q        <= y_d;
            sel_q      <= cur_sel;
            s1_valid_q <= vde && (cur_x < H_LEN) && (cur_y < V_LEN);
            s1_rgb_q   <= {red, green, blue};
            s1_exp_q   <= exp_rgb;
            s1_x_q     <= cur_x;
            s1_y_q     <= cur_y;
            err_q      <= err_d;
            geom_q     <= geom_d;
            lines_q    <= lines_d;
            fv_q       <= fv_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
            done_q     <= publish;
            if (publish) begin
                pass_q     <= (err_d == '0) && !geom_fin;
                err_out_q  <= err_d;
                geom_out_q <= geom_fin;
                fv_out_q   <= fv_d;
                fx_out_q   <= fx_d;
                fy_out_q   <= fy_d;
            end
        end
    end

    assign frame_done      = done_q;
    assign frame_pass      = pass_q;
    assign err_count       = err_out_q;
    assign geom_err        = geom_out_q;
    assign first_err_valid = fv_out_q;
    assign first_err_x     = fx_out_q;
    assign first_err_y     = fy_out_q;

endmodule
